// File: rtl/puf_ctrl_pkg.sv
// rtl/puf_ctrl_pkg.sv - shared types and helpers for the PUF response sequencer
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } puf_ctrl_state_t;

  localparam int CHAL_W = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// rtl/puf_sync2.sv - two-flop synchronizer for the asynchronous PUF output bit
module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_resp_ctrl.sv
// rtl/puf_resp_ctrl.sv - sweeps challenges over a ring-oscillator PUF cell and assembles the response word
module puf_resp_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_CHAL   = 8,
  parameter int CHAL_W     = puf_ctrl_pkg::CHAL_W,
  parameter int WINDOW     = 1024,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHAL_W-1:0]   chal_base,
  output logic                busy,
  output logic                osc_en,
  output logic                ctr_clr,
  output logic [CHAL_W-1:0]   challenge,
  input  logic                puf_bit,
  output logic [NUM_CHAL-1:0] resp,
  output logic                resp_valid,
  input  logic                resp_ready
);

  localparam int MAX_A = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int MAX_D = (MAX_A > CLR_CYCLES) ? MAX_A : CLR_CYCLES;
  localparam int CNT_W = clog2(MAX_D) + 1;
  localparam int IDX_W = clog2(NUM_CHAL) + 1;

  puf_ctrl_state_t    state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic [IDX_W-1:0]   idx, idx_inc;
  logic [CHAL_W-1:0]  base_q;
  logic               puf_bit_s;
  logic               last_idx;

  puf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_bit),
    .q   (puf_bit_s)
  );

  assign last_idx = (idx == IDX_W'(NUM_CHAL - 1));
  assign idx_inc  = idx + IDX_W'(1);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_CLEAR;
      ST_CLEAR:  if (cnt == '0) state_n = ST_RUN;
      ST_RUN:    if (cnt == '0) state_n = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_n = ST_SAMPLE;
      ST_SAMPLE: state_n = last_idx ? ST_DONE : ST_CLEAR;
      ST_DONE:   if (resp_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Counter holds remaining cycles minus one for the state being entered.
  always_comb begin
    cnt_load = '0;
    case (state_n)
      ST_CLEAR:  cnt_load = CNT_W'(CLR_CYCLES - 1);
      ST_RUN:    cnt_load = CNT_W'(WINDOW - 1);
      ST_SETTLE: cnt_load = CNT_W'(SETTLE - 1);
      default:   cnt_load = '0;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      osc_en     <= 1'b0;
      ctr_clr    <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      osc_en     <= (state_n == ST_RUN);
      ctr_clr    <= (state_n == ST_CLEAR);
      resp_valid <= (state_n == ST_DONE);
      if (state_n != state) cnt <= cnt_load;
      else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      idx       <= '0;
      challenge <= '0;
      resp      <= '0;
    end else if (state == ST_IDLE && start) begin
      base_q    <= chal_base;
      idx       <= '0;
      challenge <= chal_base;
      resp      <= '0;
    end else if (state == ST_SAMPLE) begin
      for (int i = 0; i < NUM_CHAL; i++) begin
        if (idx == IDX_W'(i)) resp[i] <= puf_bit_s;
      end
      if (!last_idx) begin
        idx       <= idx_inc;
        challenge <= base_q + CHAL_W'(idx_inc);
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// tb/tb_puf_resp_ctrl.sv - self-checking bench for the PUF response sequencer
module tb_puf_resp_ctrl;

  localparam int NC  = 8;
  localparam int WIN = 16;
  localparam int CLR = 2;
  localparam int STL = 3;
  localparam int L   = CLR + WIN + STL + 1;

  typedef struct {
    logic [2:0] base;
    logic [7:0] pat;
    logic [7:0] exp;
    int         stall;
    int         busy_pulse;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] chal_base;
  logic       busy, osc_en, ctr_clr, puf_bit, resp_valid, resp_ready;
  logic [2:0] challenge;
  logic [7:0] resp;
  logic [7:0] pat;

  logic [7:0] sb_q[$];
  vec_t       vecs[5];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign puf_bit = pat[challenge];

  puf_resp_ctrl #(
    .NUM_CHAL   (NC),
    .CHAL_W     (3),
    .WINDOW     (WIN),
    .CLR_CYCLES (CLR),
    .SETTLE     (STL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chal_base  (chal_base),
    .busy       (busy),
    .osc_en     (osc_en),
    .ctr_clr    (ctr_clr),
    .challenge  (challenge),
    .puf_bit    (puf_bit),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int         bad;
    int         k, p, w;
    logic [2:0] exp_ch;
    logic [7:0] exp_r;
    @(negedge clk);
    pat        = v.pat;
    chal_base  = v.base;
    start      = 1'b1;
    resp_ready = (v.stall == 0);
    sb_q.push_back(v.exp);
    bad = 0;
    for (int t = 1; t <= NC * L; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      k = (t - 1) / L;
      p = (t - 1) % L;
      exp_ch = 3'(int'(v.base) + k);
      if (challenge !== exp_ch) bad++;
      if (osc_en !== ((p >= CLR) && (p < CLR + WIN))) bad++;
      if (ctr_clr !== (p < CLR)) bad++;
      if (busy !== 1'b1 || resp_valid !== 1'b0) bad++;
      if (t == v.busy_pulse) begin
        start = 1'b1;
        chal_base = 3'd2;
      end else if (t == v.busy_pulse + 1) begin
        start = 1'b0;
        chal_base = v.base;
      end
    end
    chk("sweep_sequence", bad, 0);
    @(negedge clk);
    chk("valid_latency", resp_valid, 1);
    w = 0;
    while (!resp_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("valid_timeout", resp_valid, 1);
    exp_r = sb_q.pop_front();
    chk("resp_word", resp, exp_r);
    if (v.stall != 0) begin
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (resp_valid !== 1'b1 || resp !== exp_r || busy !== 1'b1) bad++;
        @(negedge clk);
      end
      chk("stall_stable", bad, 0);
      resp_ready = 1'b1;
      start      = 1'b1;
      chal_base  = v.base + 3'd3;
      @(negedge clk);
      start = 1'b0;
      chk("stall_valid_drop", resp_valid, 0);
      chk("stall_busy_drop", busy, 0);
      @(negedge clk);
      chk("handoff_start_ignored", {busy, ctr_clr}, 0);
      chk("resp_held_idle", resp, exp_r);
    end else begin
      @(negedge clk);
      chk("handoff_valid_drop", resp_valid, 0);
      chk("handoff_busy_drop", busy, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    vecs[0] = '{base: 3'd0, pat: 8'hFF, exp: 8'hFF, stall: 0, busy_pulse: -5};
    vecs[1] = '{base: 3'd5, pat: 8'hA6, exp: 8'h35, stall: 1, busy_pulse: -5};
    vecs[2] = '{base: 3'd3, pat: 8'h00, exp: 8'h00, stall: 0, busy_pulse: -5};
    vecs[3] = '{base: 3'd7, pat: 8'h0F, exp: 8'h1E, stall: 0, busy_pulse: -5};
    vecs[4] = '{base: 3'd0, pat: 8'h81, exp: 8'h81, stall: 0, busy_pulse: 50};

    rst        = 1'b0;
    start      = 1'b0;
    chal_base  = 3'd5;
    resp_ready = 1'b1;
    pat        = 8'hFF;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      if ({busy, osc_en, ctr_clr, resp_valid, challenge, resp} !== '0) bad++;
    end
    chk("reset_outputs", bad, 0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {busy, osc_en, ctr_clr, resp_valid}, 0);

    for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

    @(negedge clk);
    pat       = 8'hFF;
    chal_base = 3'd0;
    start     = 1'b1;
    sb_q.push_back(8'hFF);
    @(negedge clk);
    start = 1'b0;
    repeat (3 * L + CLR + 5 - 1) @(negedge clk);
    chk("abort_in_run", {osc_en, challenge}, {1'b1, 3'd3});
    #2 rst = 1'b0;
    #1 chk("abort_async", {busy, osc_en, ctr_clr, resp_valid, challenge, resp}, 0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    run_sweep('{base: 3'd4, pat: 8'h0F, exp: 8'hF0, stall: 0, busy_pulse: -5});

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
